// File: rtl/pc_sequencer_if.sv
// Signal bundle between pc_sequencer and its pc register, instruction memory and decode stage.
// The master modport is the sequencer side; the slave modport is the surrounding pipeline.
interface pc_sequencer_if #(
    parameter int W = 32
);
    logic [W-1:0] pc_cur;
    logic [W-1:0] pc_next;
    logic         pc_we;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [W-1:0] instr_pc;
    logic         instr_ready;
    logic         stall;
    logic         redirect_valid;
    logic [W-1:0] redirect_target;
    logic         halt;
    logic         resume;
    logic         halted;

    modport master (
        input  pc_cur, imem_ack, imem_rdata, instr_ready, stall,
               redirect_valid, redirect_target, halt, resume,
        output pc_next, pc_we, imem_req, imem_addr, instr_valid, instr, instr_pc, halted
    );

    modport slave (
        output pc_cur, imem_ack, imem_rdata, instr_ready, stall,
               redirect_valid, redirect_target, halt, resume,
        input  pc_next, pc_we, imem_req, imem_addr, instr_valid, instr, instr_pc, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch sequencer: picks the next PC, runs the imem req/ack handshake, presents words to decode.
// Latency: ack -> instr_valid one cycle later; pc_next/pc_we/imem_req are combinational from state and inputs.
// Backpressure: ISSUE holds the word while !instr_ready or stall; optional misalign trap under PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter int           W            = 32,
    parameter int           STEP         = 4,
    parameter logic [W-1:0] RESET_VECTOR = '0,
    parameter logic [W-1:0] TRAP_VECTOR  = W'(32'h100)
) (
    input  logic           clk,
    input  logic           rst,
`ifdef PC_MISALIGN_TRAP_EN
    output logic           misalign_err,
`endif
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALT} state_t;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [W-1:0] STEP_W     = W'(STEP);
    localparam logic [W-1:0] ALIGN_MASK = W'(STEP - 1);

    state_t       state_q, state_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [W-1:0] instr_pc_q, instr_pc_d;
    logic         pend_vld_q, pend_vld_d;
    logic [W-1:0] pend_tgt_q, pend_tgt_d;

    logic         apply_vld;
    logic [W-1:0] apply_tgt;
    logic         seq_we;
    logic [W-1:0] seq_next;
    logic         imem_req_c;
    logic         trap_hit;
    logic         pc_we_c;
    logic [W-1:0] pc_next_c;

    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pend_vld_d    = pend_vld_q;
        pend_tgt_d    = pend_tgt_q;
        apply_vld     = 1'b0;
        apply_tgt     = '0;
        seq_we        = 1'b0;
        seq_next      = '0;
        imem_req_c    = 1'b0;

        case (state_q)
            BOOT: begin
                seq_we   = 1'b1;
                seq_next = RESET_VECTOR;
                state_d  = FETCH;
            end
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    // A redirect seen at any point during this fetch makes the returned word stale.
                    if (bus.redirect_valid || pend_vld_q) begin
                        apply_vld  = 1'b1;
                        apply_tgt  = bus.redirect_valid ? bus.redirect_target : pend_tgt_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = bus.pc_cur;
                        seq_we        = 1'b1;
                        seq_next      = bus.pc_cur + STEP_W;
                        state_d       = ISSUE;
                    end
                end else if (bus.redirect_valid) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = bus.redirect_target;
                end
            end
            ISSUE: begin
                if (bus.redirect_valid) begin
                    apply_vld     = 1'b1;
                    apply_tgt     = bus.redirect_target;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (bus.instr_ready && !bus.stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = bus.halt ? HALT : FETCH;
                end
            end
            HALT: begin
                if (bus.redirect_valid) begin
                    apply_vld = 1'b1;
                    apply_tgt = bus.redirect_target;
                end
                if (bus.resume) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign trap_hit  = TRAP_EN && apply_vld && ((apply_tgt & ALIGN_MASK) != '0);
    assign pc_we_c   = apply_vld | seq_we;
    assign pc_next_c = apply_vld ? (trap_hit ? TRAP_VECTOR : apply_tgt) : seq_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            pend_vld_q    <= 1'b0;
            pend_tgt_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            pend_vld_q    <= pend_vld_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.pc_we       = rst & pc_we_c;
    assign bus.pc_next     = rst ? pc_next_c : '0;
    assign bus.imem_req    = rst & imem_req_c;
    assign bus.imem_addr   = rst ? bus.pc_cur : '0;
    assign bus.halted      = rst & (state_q == HALT);
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_err = rst & trap_hit;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the pc register, drives imem/decode, scores issued words against a queue.
module tb_pc_sequencer;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0]  word;
        logic [W-1:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    pc_sequencer_if #(.W(W)) bus ();

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_err;
`endif

    pc_sequencer #(
        .W(W), .STEP(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .bus(bus)
    );

    // The external pc register the sequencer writes through pc_next/pc_we.
    always @(posedge clk) begin
        if (bus.pc_we === 1'b1) bus.pc_cur <= bus.pc_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.instr_ready = 0; bus.stall = 0;
        bus.redirect_valid = 0; bus.redirect_target = '0; bus.halt = 0; bus.resume = 0;
        #1 rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h@%h want 0@0", bus.instr, bus.instr_pc); end
        n_cmp++; if (bus.pc_we !== 1'b0 || bus.imem_req !== 1'b0 || bus.halted !== 1'b0 || bus.pc_next !== 32'h0) begin
            n_err++; $display("FAIL rst_comb: we=%b req=%b halted=%b next=%h want all 0", bus.pc_we, bus.imem_req, bus.halted, bus.pc_next); end
        tick();
    endtask

    task automatic test_boot_fetch();
        rst = 1'b1;
        bus.imem_ack = 1; bus.imem_rdata = 32'h11111111;
        sb.push_back('{word: 32'h11111111, pc: 32'h0});
        @(negedge clk);
        n_cmp++; if (bus.pc_we !== 1'b1 || bus.pc_next !== 32'h0 || bus.imem_req !== 1'b0) begin
            n_err++; $display("FAIL boot: we=%b next=%h req=%b want 1/0/0", bus.pc_we, bus.pc_next, bus.imem_req); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.pc_we !== 1'b1 || bus.pc_next !== 32'h4) begin
            n_err++; $display("FAIL fetch0: req=%b addr=%h we=%b next=%h want 1/0/1/4", bus.imem_req, bus.imem_addr, bus.pc_we, bus.pc_next); end
        tick();
        bus.imem_ack = 0;
        @(negedge clk);
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h11111111 || bus.instr_pc !== 32'h0) begin
            n_err++; $display("FAIL issue0: v=%b %h@%h want 1 11111111@0", bus.instr_valid, bus.instr, bus.instr_pc); end
        tick();
    endtask

    task automatic test_delayed_ack();
        bus.instr_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL t2_pop0: scoreboard empty"); end
        else begin e = sb.pop_front();
            if (bus.instr_valid !== 1'b1 || bus.instr !== e.word || bus.instr_pc !== e.pc) begin
                n_err++; $display("FAIL t2_pop0: got v=%b %h@%h want 1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc); end
        end
        tick();
        bus.instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.pc_we !== 1'b0) begin
                n_err++; $display("FAIL wait_ack%0d: req=%b addr=%h we=%b want 1/4/0", i, bus.imem_req, bus.imem_addr, bus.pc_we); end
            tick();
        end
        bus.imem_ack = 1; bus.imem_rdata = 32'h22222222;
        sb.push_back('{word: 32'h22222222, pc: 32'h4});
        @(negedge clk);
        n_cmp++; if (bus.pc_we !== 1'b1 || bus.pc_next !== 32'h8) begin
            n_err++; $display("FAIL ack4: we=%b next=%h want 1/8", bus.pc_we, bus.pc_next); end
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL t2_pop1: scoreboard empty"); end
        else begin e = sb.pop_front();
            if (bus.instr_valid !== 1'b1 || bus.instr !== e.word || bus.instr_pc !== e.pc) begin
                n_err++; $display("FAIL t2_pop1: got v=%b %h@%h want 1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc); end
        end
        tick();
        bus.instr_ready = 0;
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1; bus.redirect_target = 32'h40;
        @(negedge clk);
        n_cmp++; if (bus.imem_addr !== 32'h8 || bus.pc_we !== 1'b0) begin
            n_err++; $display("FAIL redir_latch: addr=%h we=%b want 8/0", bus.imem_addr, bus.pc_we); end
        tick();
        bus.redirect_valid = 0; bus.redirect_target = '0;
        @(negedge clk);
        n_cmp++; if (bus.pc_we !== 1'b0) begin n_err++; $display("FAIL redir_hold: we=%b want 0", bus.pc_we); end
        tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (bus.pc_we !== 1'b1 || bus.pc_next !== 32'h40) begin
            n_err++; $display("FAIL redir_apply: we=%b next=%h want 1/40", bus.pc_we, bus.pc_next); end
        tick();
        bus.imem_ack = 0;
        @(negedge clk);
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            n_err++; $display("FAIL redir_drop: v=%b req=%b addr=%h want 0/1/40", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        tick();
    endtask

    task automatic test_stall_wrap();
        bus.imem_ack = 1; bus.imem_rdata = 32'h33333333;
        sb.push_back('{word: 32'h33333333, pc: 32'h40});
        @(negedge clk);
        n_cmp++; if (bus.pc_next !== 32'h44) begin n_err++; $display("FAIL ack40: next=%h want 44", bus.pc_next); end
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1; bus.stall = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.imem_req !== 1'b0) begin
                n_err++; $display("FAIL stall%0d: v=%b pc=%h req=%b want 1/40/0", i, bus.instr_valid, bus.instr_pc, bus.imem_req); end
            tick();
        end
        bus.stall = 0;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL t4_pop: scoreboard empty"); end
        else begin e = sb.pop_front();
            if (bus.instr_valid !== 1'b1 || bus.instr !== e.word || bus.instr_pc !== e.pc) begin
                n_err++; $display("FAIL t4_pop: got v=%b %h@%h want 1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc); end
        end
        tick();
        bus.instr_ready = 0;
        bus.redirect_valid = 1; bus.redirect_target = 32'hFFFFFFFC; bus.imem_ack = 1; bus.imem_rdata = 32'h0BADF00D;
        @(negedge clk);
        n_cmp++; if (bus.pc_we !== 1'b1 || bus.pc_next !== 32'hFFFFFFFC) begin
            n_err++; $display("FAIL redir_now: we=%b next=%h want 1/fffffffc", bus.pc_we, bus.pc_next); end
        tick();
        bus.redirect_valid = 0; bus.imem_rdata = 32'h44444444;
        sb.push_back('{word: 32'h44444444, pc: 32'hFFFFFFFC});
        @(negedge clk);
        n_cmp++; if (bus.imem_addr !== 32'hFFFFFFFC || bus.pc_next !== 32'h0 || bus.pc_we !== 1'b1) begin
            n_err++; $display("FAIL wrap: addr=%h next=%h we=%b want fffffffc/0/1", bus.imem_addr, bus.pc_next, bus.pc_we); end
        tick();
        bus.imem_ack = 0;
    endtask

    task automatic test_halt();
        bus.halt = 1; bus.instr_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL t5_pop: scoreboard empty"); end
        else begin e = sb.pop_front();
            if (bus.instr_valid !== 1'b1 || bus.instr !== e.word || bus.instr_pc !== e.pc) begin
                n_err++; $display("FAIL t5_pop: got v=%b %h@%h want 1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc); end
        end
        tick();
        bus.instr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                n_err++; $display("FAIL halt%0d: halted=%b req=%b v=%b want 1/0/0", i, bus.halted, bus.imem_req, bus.instr_valid); end
            tick();
        end
        bus.resume = 1;
        tick();
        bus.resume = 0; bus.halt = 0;
        @(negedge clk);
        n_cmp++; if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_err++; $display("FAIL resume: halted=%b req=%b addr=%h want 0/1/0", bus.halted, bus.imem_req, bus.imem_addr); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.imem_ack = 1; bus.imem_rdata = 32'h55555555;
        tick();
        bus.imem_ack = 0;
        @(negedge clk);
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL pre_arst: v=%b want 1", bus.instr_valid); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.pc_we !== 1'b0 || bus.imem_req !== 1'b0) begin
            n_err++; $display("FAIL arst: v=%b instr=%h we=%b req=%b want 0/0/0/0", bus.instr_valid, bus.instr, bus.pc_we, bus.imem_req); end
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.pc_we !== 1'b1 || bus.pc_next !== 32'h0) begin
            n_err++; $display("FAIL reboot: we=%b next=%h want 1/0", bus.pc_we, bus.pc_next); end
        tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'h66666666;
        sb.push_back('{word: 32'h66666666, pc: 32'h0});
        @(negedge clk);
        n_cmp++; if (bus.imem_addr !== 32'h0 || bus.pc_next !== 32'h4) begin
            n_err++; $display("FAIL refetch: addr=%h next=%h want 0/4", bus.imem_addr, bus.pc_next); end
        tick();
        bus.imem_ack = 0; bus.instr_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL t6_pop: scoreboard empty"); end
        else begin e = sb.pop_front();
            if (bus.instr_valid !== 1'b1 || bus.instr !== e.word || bus.instr_pc !== e.pc) begin
                n_err++; $display("FAIL t6_pop: got v=%b %h@%h want 1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc); end
        end
        tick();
        bus.instr_ready = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] word;
        for (int i = 0; i < 4; i++) begin
            word = 32'hA0000000 + 32'(i);
            bus.imem_ack = 1; bus.imem_rdata = word; bus.instr_ready = 1;
            sb.push_back('{word: word, pc: 32'(4 + 4 * i)});
            @(negedge clk);
            n_cmp++; if (bus.pc_we !== 1'b1 || bus.pc_next !== 32'(8 + 4 * i)) begin
                n_err++; $display("FAIL b2b_next%0d: we=%b next=%h want 1/%h", i, bus.pc_we, bus.pc_next, 32'(8 + 4 * i)); end
            tick();
            bus.imem_ack = 0;
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin n_err++; $display("FAIL b2b_pop%0d: scoreboard empty", i); end
            else begin e = sb.pop_front();
                if (bus.instr_valid !== 1'b1 || bus.instr !== e.word || bus.instr_pc !== e.pc) begin
                    n_err++; $display("FAIL b2b_pop%0d: got v=%b %h@%h want 1 %h@%h", i, bus.instr_valid, bus.instr, bus.instr_pc, e.word, e.pc); end
            end
            tick();
        end
        bus.instr_ready = 0;
    endtask

    task automatic test_misalign();
        bus.redirect_valid = 1; bus.redirect_target = 32'h42; bus.imem_ack = 1; bus.imem_rdata = 32'h77777777;
        @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
        n_cmp++; if (bus.pc_next !== 32'h100 || misalign_err !== 1'b1) begin
            n_err++; $display("FAIL trap: next=%h err=%b want 100/1", bus.pc_next, misalign_err); end
`else
        n_cmp++; if (bus.pc_next !== 32'h42 || bus.pc_we !== 1'b1) begin
            n_err++; $display("FAIL verbatim: next=%h we=%b want 42/1", bus.pc_next, bus.pc_we); end
`endif
        tick();
        bus.redirect_valid = 0; bus.imem_ack = 0;
        @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
        n_cmp++; if (misalign_err !== 1'b0 || bus.imem_addr !== 32'h100) begin
            n_err++; $display("FAIL trap_after: err=%b addr=%h want 0/100", misalign_err, bus.imem_addr); end
`else
        n_cmp++; if (bus.imem_addr !== 32'h42 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL verbatim_after: addr=%h v=%b want 42/0", bus.imem_addr, bus.instr_valid); end
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_boot_fetch();
        test_delayed_ack();
        test_redirect();
        test_stall_wrap();
        test_halt();
        test_async_reset();
        test_back_to_back();
        test_misalign();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d entries left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
